// File: rtl/led_anim_sequencer_pkg.sv
// Shared constants for the LED animation sequencer: playback modes, FSM state codes
// and the all-LEDs-off pattern for the active-low LED bus.
package led_anim_pkg;

  localparam int LED_W_DEF = 7;

  localparam logic [1:0] MODE_LOOP    = 2'b00;
  localparam logic [1:0] MODE_BOUNCE  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LED_W_DEF-1:0] LED_ALL_OFF = {LED_W_DEF{1'b1}};

  // Playback settings captured when a run starts.
  typedef struct packed {
    logic       dir;
    logic [1:0] mode;
  } play_cfg_t;

  // The unused mode code 2'b11 plays back as a plain loop.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    norm_mode = (m == 2'b11) ? MODE_LOOP : m;
  endfunction

endpackage

// File: rtl/led_anim_sequencer_if.sv
// Control, status and pattern-ROM signals of the LED animation sequencer.
// master = parent/controller side, slave = the sequencer itself.
interface led_anim_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int LED_W  = 7
);

  logic              start;
  logic              stop;
  logic              dir;
  logic [1:0]        mode;
  logic [1:0]        speed;
  logic [ADDR_W-1:0] rom_addr;
  logic [LED_W-1:0]  rom_data;
  logic [LED_W-1:0]  led_n;
  logic              busy;
  logic              step_stb;
  logic              done;

  modport master (
    output start, stop, dir, mode, speed, rom_data,
    input  rom_addr, led_n, busy, step_stb, done
  );

  modport slave (
    input  start, stop, dir, mode, speed, rom_data,
    output rom_addr, led_n, busy, step_stb, done
  );

endinterface

// File: rtl/led_anim_sequencer_tick_gen.sv
// Step timebase: a TICK_DIV prescaler followed by a speed sub-counter; step pulses
// once every TICK_DIV << speed cycles while clr is low.
module led_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       step
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_reg;
  logic [2:0]    sub_reg;
  logic [1:0]    speed_reg;
  logic [2:0]    sub_last;
  logic          wrap;

  // Speed is latched at every step boundary, so a change mid-period only
  // affects the period after the next step.
  assign sub_last = 3'((4'd1 << speed_reg) - 4'd1);
  assign wrap     = (presc_reg == PRESC_LAST);
  assign step     = wrap && (sub_reg == sub_last) && !clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
      sub_reg   <= '0;
      speed_reg <= '0;
    end else if (clr || step) begin
      presc_reg <= '0;
      sub_reg   <= '0;
      speed_reg <= speed;
    end else if (wrap) begin
      presc_reg <= '0;
      sub_reg   <= sub_reg + 3'd1;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

endmodule

// File: rtl/led_anim_sequencer.sv
// LED animation sequencer: walks a step index through the pattern ROM in loop,
// bounce or one-shot order and registers the returned active-low pattern to the LEDs.
module led_anim_sequencer
  import led_anim_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000,
  parameter int ADDR_W   = 7,
  parameter int LED_W    = LED_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  led_anim_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  play_cfg_t         cfg_reg, cfg_next;
  logic [LED_W-1:0]  led_reg, led_next;
  logic              busy_reg, stb_reg, stb_next, done_reg;

  logic              tick_clr, step, load, run_next, at_end;
  logic [ADDR_W-1:0] addr_fwd, addr_back;

  // Counters are held clear outside RUN and restart on any start/stop pulse.
  assign tick_clr = (state_reg != S_RUN) || bus.start || bus.stop;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (tick_clr),
    .speed (bus.speed),
    .step  (step)
  );

  // stop only outranks start while running; in IDLE/DONE a start always loads.
  assign load = bus.start && !((state_reg == S_RUN) && bus.stop);

  // "fwd" is one index along the current direction of travel, "back" one against it.
  assign addr_fwd  = cfg_reg.dir ? addr_reg - ADDR_W'(1) : addr_reg + ADDR_W'(1);
  assign addr_back = cfg_reg.dir ? addr_reg + ADDR_W'(1) : addr_reg - ADDR_W'(1);
  assign at_end    = cfg_reg.dir ? (addr_reg == ADDR_FIRST) : (addr_reg == ADDR_LAST);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cfg_next   = cfg_reg;
    stb_next   = 1'b0;
    if (load) begin
      state_next    = S_RUN;
      addr_next     = bus.dir ? ADDR_LAST : ADDR_FIRST;
      cfg_next.dir  = bus.dir;
      cfg_next.mode = norm_mode(bus.mode);
    end else begin
      case (state_reg)
        S_RUN: begin
          if (bus.stop) begin
            state_next = S_IDLE;
          end else if (step) begin
            case (cfg_reg.mode)
              MODE_BOUNCE: begin
                stb_next = 1'b1;
                if (at_end) begin
                  cfg_next.dir = ~cfg_reg.dir;
                  addr_next    = addr_back;
                end else begin
                  addr_next = addr_fwd;
                end
              end
              MODE_ONESHOT: begin
                if (at_end) begin
                  state_next = S_DONE;
                end else begin
                  addr_next = addr_fwd;
                  stb_next  = 1'b1;
                end
              end
              default: begin
                addr_next = addr_fwd;
                stb_next  = 1'b1;
              end
            endcase
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // LEDs follow the ROM only while the machine is (or is entering) RUN.
  assign run_next = (state_next == S_RUN);

  for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
    assign led_next[gi] = run_next ? bus.rom_data[gi] : LED_ALL_OFF[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      cfg_reg   <= '0;
      led_reg   <= LED_ALL_OFF;
      busy_reg  <= 1'b0;
      stb_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cfg_reg   <= cfg_next;
      led_reg   <= led_next;
      busy_reg  <= run_next;
      stb_reg   <= stb_next;
      done_reg  <= (state_next == S_DONE);
    end
  end

  assign bus.rom_addr = addr_reg;
  assign bus.led_n    = led_reg;
  assign bus.busy     = busy_reg;
  assign bus.step_stb = stb_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_led_anim_sequencer.sv
// Directed plus randomized checks of the LED sequencer against a position-based
// playback model (triangle wave for bounce, modular count for loop/one-shot).
module tb_led_anim_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_anim_sequencer_if #(.ADDR_W(7), .LED_W(7)) bus ();
  assign bus.rom_data = ~bus.rom_addr;

  led_anim_sequencer #(
    .TICK_DIV (4),
    .ADDR_W   (7),
    .LED_W    (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [6:0] prev_addr = '0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; LEDs must be off outside RUN and show the previous cycle's address in RUN.
  task automatic cyc();
    logic [6:0] exp_led;
    @(posedge clk);
    #1;
    exp_led = (bus.busy === 1'b1) ? ~prev_addr : 7'h7F;
    check("led_n", {25'b0, bus.led_n}, {25'b0, exp_led});
    prev_addr = bus.rom_addr;
  endtask

  // kind: 1 = step_stb seen, 2 = done seen, 0 = budget expired
  task automatic wait_evt(input int budget, output int kind, output int waited);
    kind = 0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      waited = i + 1;
      if (bus.step_stb === 1'b1) begin
        kind = 1;
        break;
      end
      if (bus.done === 1'b1) begin
        kind = 2;
        break;
      end
    end
  endtask

  // Address after k steps of a run that started with the given mode/dir.
  function automatic int model_addr(input int mode, input int dir, input int k);
    int ph;
    if (mode == 1) begin
      ph = ((dir != 0) ? 127 : 0) + k;
      ph = ph % 254;
      return (ph <= 127) ? ph : 254 - ph;
    end
    if (dir != 0) return ((127 - k) % 128 + 128) % 128;
    return k % 128;
  endfunction

  task automatic pulse_start(input int mode, input int dir);
    bus.mode  = 2'(mode);
    bus.dir   = dir[0];
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic play(input string tag, input int mode, input int dir, input int nsteps,
                      input int period, input bit scramble);
    int kind, waited;
    $display("run %s: mode=%0d dir=%0d steps=%0d period=%0d", tag, mode, dir, nsteps, period);
    pulse_start(mode, dir);
    check({tag, "_busy0"}, bus.busy, 1);
    check({tag, "_addr0"}, bus.rom_addr, model_addr(mode, dir, 0));
    if (scramble) begin
      bus.mode = 2'($urandom);
      bus.dir  = 1'($urandom);
    end
    for (int k = 1; k <= nsteps; k++) begin
      wait_evt(period * 3, kind, waited);
      if (mode == 2 && k == 128) begin
        check({tag, "_done_kind"}, kind, 2);
        check({tag, "_done_lat"}, waited, period);
        check({tag, "_done_stb"}, bus.step_stb, 0);
        check({tag, "_done_busy"}, bus.busy, 0);
        check({tag, "_done_led"}, bus.led_n, 7'h7F);
        check({tag, "_done_addr"}, bus.rom_addr, model_addr(mode, dir, 127));
        cyc();
        check({tag, "_done_len"}, bus.done, 0);
        check({tag, "_idle_busy"}, bus.busy, 0);
        return;
      end
      check({tag, "_kind"}, kind, 1);
      check({tag, "_spacing"}, waited, period);
      check({tag, "_addr"}, bus.rom_addr, model_addr(mode, dir, k));
    end
  endtask

  initial begin
    int kind, waited, held, mode, dir, n, sp;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.dir   = 1'b0;
    bus.mode  = 2'b00;
    bus.speed = 2'd0;
    repeat (3) cyc();
    rst = 1'b0;

    // 1. idle after reset
    $display("run idle after reset");
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_addr", bus.rom_addr, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_stb", bus.step_stb, 0);
      check("idle_done", bus.done, 0);
    end

    // 2-4. loop, bounce (restarted from RUN), one-shot
    play("loop", 0, 0, 130, 4, 1'b0);
    play("bounce", 1, 1, 130, 4, 1'b0);
    play("oneshot", 2, 0, 128, 4, 1'b0);

    // 5. speed 2, then drop to 0 mid-period
    $display("run speed change");
    bus.speed = 2'd2;
    pulse_start(0, 0);
    wait_evt(64, kind, waited);
    check("spd_w1", waited, 16);
    check("spd_a1", bus.rom_addr, 1);
    wait_evt(64, kind, waited);
    check("spd_w2", waited, 16);
    check("spd_a2", bus.rom_addr, 2);
    repeat (5) cyc();
    bus.speed = 2'd0;
    wait_evt(64, kind, waited);
    check("spd_w3", waited, 11);
    check("spd_a3", bus.rom_addr, 3);
    wait_evt(64, kind, waited);
    check("spd_w4", waited, 4);
    check("spd_a4", bus.rom_addr, 4);
    wait_evt(64, kind, waited);
    check("spd_w5", waited, 4);
    check("spd_a5", bus.rom_addr, 5);

    // 6. stop+start together in RUN -> IDLE without done
    $display("run stop and start together");
    cyc();
    held = int'(bus.rom_addr);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_busy", bus.busy, 0);
    check("ss_done", bus.done, 0);
    check("ss_addr", bus.rom_addr, held);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("ss_idle_stb", bus.step_stb, 0);
      check("ss_idle_done", bus.done, 0);
      check("ss_idle_addr", bus.rom_addr, held);
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check("stop_idle_busy", bus.busy, 0);
    check("stop_idle_addr", bus.rom_addr, held);

    // reset at address 50
    play("pre_rst", 0, 0, 50, 4, 1'b0);
    rst = 1'b1;
    cyc();
    check("rst_addr", bus.rom_addr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_stb", bus.step_stb, 0);
    check("rst_done", bus.done, 0);
    check("rst_led", bus.led_n, 7'h7F);
    rst = 1'b0;
    repeat (6) cyc();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_addr", bus.rom_addr, 0);

    // randomized runs; dir/mode are scrambled after start and must be ignored
    for (int r = 0; r < 8; r++) begin
      mode = int'($urandom_range(0, 3));
      dir  = int'($urandom_range(0, 1));
      sp   = int'($urandom_range(0, 1));
      n    = (mode == 2) ? 128 : int'($urandom_range(1, 200));
      bus.speed = 2'(sp);
      play($sformatf("rnd%0d", r), mode, dir, n, 4 << sp, 1'b1);
      if (bus.busy === 1'b1) begin
        held = int'(bus.rom_addr);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        check("rnd_stop_busy", bus.busy, 0);
        check("rnd_stop_done", bus.done, 0);
        check("rnd_stop_addr", bus.rom_addr, held);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
